// File: rtl/wdt_ctrl.sv
// Watchdog sequencer: prescaled timeout counter with kick, early-warning irq and fixed-length reset request.
// Single-cycle registered outputs; no backpressure, kick/clear strobes are sampled every cycle.
module wdt_ctrl #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16,
    parameter int RST_LEN = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [CNT_W-1:0]   warn_i,
    input  logic [CNT_W-1:0]   timeout_i,
    input  logic               kick_i,
    input  logic               clr_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               irq_o,
    output logic               rst_req_o,
    output logic               bite_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } state_t;

    localparam int              BL_W    = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(RST_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BL_W-1:0]    blen_q, blen_d;
    logic               bite_q, bite_d;
    logic               tick, bite_done, restart, bite_enter;

    assign tick      = (presc_q == presc_i);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign bite_done = (blen_q == BL_LAST);
    // Disable outranks kick; both discard any tick in the same cycle.
    assign restart   = !en_i || kick_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            blen_q  <= '0;
            bite_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            blen_q  <= blen_d;
            bite_q  <= bite_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en_i) state_d = COUNT;
            COUNT, WARN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (kick_i) begin
                    state_d = COUNT;
                end else if (tick) begin
                    // Bite check first so warn >= timeout skips WARN entirely.
                    if (cnt_inc >= timeout_i)
                        state_d = BITE;
                    else if (state_q == COUNT && cnt_inc >= warn_i)
                        state_d = WARN;
                end
            end
            BITE: if (bite_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        presc_d = '0;
        blen_d  = '0;
        case (state_q)
            IDLE: cnt_d = '0;
            COUNT, WARN: begin
                if (restart) begin
                    cnt_d = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            BITE: begin
                if (bite_done) begin
                    cnt_d = '0;
                end else begin
                    blen_d = blen_q + BL_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign bite_enter = (state_d == BITE) && (state_q != BITE);

    always_comb begin
        bite_d = bite_q;
        if (bite_enter)
            bite_d = 1'b1;
        else if (clr_i)
            bite_d = 1'b0;
    end

    always_comb begin
        irq_o     = (state_q == WARN);
        rst_req_o = (state_q == BITE);
        state_o   = state_q;
        cnt_o     = cnt_q;
        bite_o    = bite_q;
    end

endmodule

// File: tb/tb_wdt_ctrl.sv
// Bench for wdt_ctrl: directed scenarios with literal expectations plus a random run against a rule-level model.
module tb_wdt_ctrl;

    localparam int CNT_W   = 4;
    localparam int PRESC_W = 4;
    localparam int RST_LEN = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int PMOD    = 1 << PRESC_W;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               en_i, kick_i, clr_i;
    logic [PRESC_W-1:0] presc_i;
    logic [CNT_W-1:0]   warn_i, timeout_i;
    logic [CNT_W-1:0]   cnt_o;
    logic               irq_o, rst_req_o, bite_o;
    logic [1:0]         state_o;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int m_state, m_cnt, m_ph, m_blen;
    bit m_bite;

    wdt_ctrl #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .RST_LEN(RST_LEN)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .presc_i   (presc_i),
        .warn_i    (warn_i),
        .timeout_i (timeout_i),
        .kick_i    (kick_i),
        .clr_i     (clr_i),
        .cnt_o     (cnt_o),
        .irq_o     (irq_o),
        .rst_req_o (rst_req_o),
        .bite_o    (bite_o),
        .state_o   (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Reference model: state as 0..3, counter/phase as plain integers.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_ph    <= 0;
            m_blen  <= 0;
            m_bite  <= 1'b0;
        end else begin
            automatic int s     = m_state;
            automatic int c     = m_cnt;
            automatic int p     = m_ph;
            automatic int b     = m_blen;
            automatic bit bt    = m_bite;
            automatic bit enter = 1'b0;
            case (s)
                0: begin
                    c = 0;
                    p = 0;
                    if (en_i) s = 1;
                end
                1, 2: begin
                    if (!en_i) begin
                        s = 0; c = 0; p = 0;
                    end else if (kick_i) begin
                        s = 1; c = 0; p = 0;
                    end else if (p == int'(presc_i)) begin
                        p = 0;
                        c = (c < CMAX) ? c + 1 : CMAX;
                        if (c >= int'(timeout_i)) begin
                            s = 3; enter = 1'b1; b = 0;
                        end else if (s == 1 && c >= int'(warn_i)) begin
                            s = 2;
                        end
                    end else begin
                        p = (p + 1) % PMOD;
                    end
                end
                default: begin
                    b = b + 1;
                    p = 0;
                    if (b == RST_LEN) begin
                        s = 0; c = 0; b = 0;
                    end
                end
            endcase
            if (enter) bt = 1'b1;
            else if (clr_i) bt = 1'b0;
            m_state <= s;
            m_cnt   <= c;
            m_ph    <= p;
            m_blen  <= b;
            m_bite  <= bt;
        end
    end

    always @(negedge clk_i) begin
        if (chk_on && rst_ni) begin
            chk("cnt", cnt_o, m_cnt);
            chk("state", state_o, m_state);
            chk("irq", irq_o, m_state == 2);
            chk("rst_req", rst_req_o, m_state == 3);
            chk("bite", bite_o, m_bite);
        end
    end

    initial begin
        automatic int exp_st[10] = '{1, 1, 2, 2, 3, 3, 3, 3, 0, 1};
        int n, mx, nrst;
        bit irq_seen;

        rst_ni = 1'b0; en_i = 1'b0; kick_i = 1'b0; clr_i = 1'b0;
        presc_i = '0; warn_i = '0; timeout_i = '0;
        cyc();
        cyc();
        chk("reset_cnt", cnt_o, 0);
        chk("reset_state", state_o, 0);
        chk("reset_outs", {irq_o, rst_req_o, bite_o}, 0);
        rst_ni = 1'b1;
        chk_on = 1'b1;

        // Basic sequence: warn at cnt 2, bite at 4, 4-cycle pulse, re-arm.
        presc_i = 0; warn_i = 2; timeout_i = 4; en_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            chk("t1_state", state_o, exp_st[c-1]);
            chk("t1_rst_req", rst_req_o, (c >= 5 && c <= 8));
            if (c == 1) chk("t1_cnt_c1", cnt_o, 0);
            if (c == 3) chk("t1_irq_c3", {irq_o, cnt_o}, {1'b1, 4'd2});
            if (c == 5) chk("t1_bite_c5", bite_o, 1);
        end
        en_i = 1'b0; clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        cyc();

        // Prescaled: one count per 4 cycles, bite 8 cycles after COUNT entry.
        presc_i = 3; warn_i = 10; timeout_i = 2; en_i = 1'b1;
        cyc();
        n = 0; irq_seen = 1'b0;
        while (state_o != 2'd3 && n < 40) begin
            cyc();
            n++;
            irq_seen |= irq_o;
        end
        chk("t2_bite_delay", n, 8);
        chk("t2_no_irq", irq_seen, 0);
        en_i = 1'b0;
        for (int i = 0; i < 10 && state_o != 2'd0; i++) cyc();
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;

        // Periodic kicks keep the counter at or below 4.
        presc_i = 0; warn_i = 3; timeout_i = 6; en_i = 1'b1;
        mx = 0; nrst = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (int'(cnt_o) > mx) mx = int'(cnt_o);
            if (rst_req_o) nrst++;
            kick_i = (i % 5 == 0);
        end
        kick_i = 1'b0;
        chk("t3_max_cnt", mx, 4);
        chk("t3_no_rst", nrst, 0);
        en_i = 1'b0;
        cyc();
        cyc();

        // Kick beats a biting tick; disable beats kick.
        presc_i = 0; warn_i = 10; timeout_i = 3; en_i = 1'b1;
        cyc();
        cyc();
        cyc();
        kick_i = 1'b1;
        cyc();
        kick_i = 1'b0;
        chk("t4_kick_state", state_o, 1);
        chk("t4_kick_cnt", cnt_o, 0);
        kick_i = 1'b1; en_i = 1'b0;
        cyc();
        kick_i = 1'b0;
        chk("t4_dis_state", state_o, 0);

        // Pulse length unaffected by kick/disable; set beats clear on entry.
        presc_i = 0; warn_i = 10; timeout_i = 1; en_i = 1'b1;
        cyc();
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("t5_entry_state", state_o, 3);
        chk("t5_set_wins", bite_o, 1);
        kick_i = 1'b1; en_i = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!rst_req_o) break;
            n++;
        end
        kick_i = 1'b0;
        chk("t5_pulse_len", n, RST_LEN);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("t5_clr", bite_o, 0);

        // Full-range count bites at all-ones; async reset kills the pulse.
        presc_i = 0; warn_i = 4'hF; timeout_i = 4'hF; en_i = 1'b1;
        for (int i = 0; i < 40 && state_o != 2'd3; i++) cyc();
        chk("t6_sat_cnt", cnt_o, 15);
        chk("t6_state", state_o, 3);
        cyc();
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_arst_cnt", cnt_o, 0);
        chk("t6_arst_state", state_o, 0);
        chk("t6_arst_outs", {irq_o, rst_req_o, bite_o}, 0);
        en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomised run against the model.
        presc_i = 4'($urandom_range(0, 3));
        warn_i = 4'($urandom_range(2, 15));
        timeout_i = 4'($urandom_range(4, 15));
        en_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) presc_i = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) warn_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) timeout_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 3) en_i = ~en_i;
            kick_i = ($urandom_range(0, 11) == 0);
            clr_i = ($urandom_range(0, 19) == 0);
            cyc();
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_ni = 1'b0;
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
